// File: rtl/pulse_to_press_if.sv
// Request/press bundle between a pulse source and the pulse_to_press converter.
// The converter sits on the slave side; the master drives requests and observes the press.
interface pulse_to_press_if #(
  parameter int PW = 3
);
  logic          pulse_in;
  logic          press_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse_in,
    input  press_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output press_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_to_press.sv
// Turns single-cycle request pulses into active-low button presses of HOLD_CYCLES low
// followed by GAP_CYCLES high, queueing requests that arrive mid-press in a saturating counter.
module pulse_to_press #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_PENDING = 7,
  parameter int PW          = 3
) (
  input  logic            clk,
  input  logic            rst,
  pulse_to_press_if.slave bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          press_q;
  logic          busy_q;
  logic          queue_open;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    queue_open = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.pulse_in) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      S_HOLD: begin
        queue_open = 1'b1;
        if (cnt_zero) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_zero) begin
          // A request seen on the exit edge starts the next press at once instead of
          // being queued, so the queue nets pending + pulse_in - 1 and cannot overflow.
          if ((pending_q != '0) || bus.pulse_in) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
            if (!bus.pulse_in) begin
              pending_d = pending_q - 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          queue_open = 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (queue_open && bus.pulse_in) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      press_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      // Outputs are decoded from the next state so they change on the same edge as it.
      press_q    <= (state_d != S_HOLD);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.press_out = press_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_to_press.sv
// Self-checking bench for pulse_to_press: a timeline model (press start edge + queue depth)
// is compared against the DUT every cycle, with directed scenarios pinned by literal counts.
module tb_pulse_to_press;

  localparam int H  = 8;
  localparam int G  = 4;
  localparam int MX = 7;
  localparam int PW = 3;

  logic clk;
  logic rst;

  pulse_to_press_if #(.PW(PW)) bus ();

  pulse_to_press #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .MAX_PENDING(MX),
    .PW         (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge index of the current press start and the queue depth. A press is low
  // for edges [start, start+H) and busy until edge start+H+G, where a new one may begin.
  typedef struct {
    longint now;
    longint start;
    int     pend;
    bit     ovf;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.now   = 0;
    r.start = -1000;
    r.pend  = 0;
    r.ovf   = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, bit p);
    model_t r = m;
    r.now = m.now + 1;
    r.ovf = 1'b0;
    if (r.now >= m.start + H + G) begin
      if (m.pend > 0 || p) begin
        r.start = r.now;
        r.pend  = m.pend + int'(p) - 1;
      end
    end else if (p) begin
      if (m.pend < MX) r.pend = m.pend + 1;
      else             r.ovf  = 1'b1;
    end
    return r;
  endfunction

  model_t m;

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, bus.pulse_in);
  end

  // Scenario counters, cleared by the stimulus between scenarios.
  int  press_starts, low_cycles, busy_cycles, ovf_cycles, max_pend;
  bit  prev_press = 1'b1;

  always @(negedge clk) begin
    bit exp_press, exp_busy;
    exp_press = !((m.start <= m.now) && (m.now < m.start + H));
    exp_busy  = (m.now < m.start + H + G);
    check("press_out", 32'(bus.press_out), 32'(exp_press));
    check("busy",      32'(bus.busy),      32'(exp_busy));
    check("pending",   32'(bus.pending),   32'(m.pend));
    check("overflow",  32'(bus.overflow),  32'(m.ovf));
    if (prev_press === 1'b1 && bus.press_out === 1'b0) press_starts <= press_starts + 1;
    if (bus.press_out === 1'b0) low_cycles  <= low_cycles + 1;
    if (bus.busy === 1'b1)      busy_cycles <= busy_cycles + 1;
    if (bus.overflow === 1'b1)  ovf_cycles  <= ovf_cycles + 1;
    if (int'(bus.pending) > max_pend) max_pend <= int'(bus.pending);
    prev_press <= bus.press_out;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit p);
    bus.pulse_in = p;
    tick();
  endtask

  task automatic clear_counts();
    press_starts = 0;
    low_cycles   = 0;
    busy_cycles  = 0;
    ovf_cycles   = 0;
    max_pend     = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (bus.busy === 1'b0) done = 1'b1;
      else drive(1'b0);
    end
    check({name, "_idle_timeout"}, 32'(done), 32'd1);
    repeat (2) drive(1'b0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pulse_in = 1'b0;
    rst = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_press", 32'(bus.press_out), 32'd1);
    check("reset_busy",  32'(bus.busy),      32'd0);
    check("reset_pend",  32'(bus.pending),   32'd0);
    check("reset_ovf",   32'(bus.overflow),  32'd0);
    repeat (3) drive(1'b0);

    // Single isolated pulse.
    clear_counts();
    drive(1'b1);
    repeat (20) drive(1'b0);
    check("single_starts", 32'(press_starts), 32'd1);
    check("single_low",    32'(low_cycles),   32'(H));
    check("single_busy",   32'(busy_cycles),  32'(H + G));
    check("single_pend",   32'(max_pend),     32'd0);

    // Three pulses two edges apart.
    clear_counts();
    drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b0); drive(1'b1);
    wait_idle("three", 100);
    check("three_starts", 32'(press_starts), 32'd3);
    check("three_low",    32'(low_cycles),   32'(3 * H));
    check("three_busy",   32'(busy_cycles),  32'(3 * (H + G)));
    check("three_pend",   32'(max_pend),     32'd2);

    // Ten-edge burst saturates the queue and drops two requests.
    clear_counts();
    repeat (10) drive(1'b1);
    wait_idle("burst", 300);
    check("burst_starts", 32'(press_starts), 32'd8);
    check("burst_ovf",    32'(ovf_cycles),   32'd2);
    check("burst_pend",   32'(max_pend),     32'(MX));
    check("burst_busy",   32'(busy_cycles),  32'(8 * (H + G)));

    // Request exactly on the GAP exit edge chains a press with no idle cycle.
    clear_counts();
    drive(1'b1);
    repeat (H + G - 1) drive(1'b0);
    drive(1'b1);
    wait_idle("gapexit", 100);
    check("gapexit_starts", 32'(press_starts), 32'd2);
    check("gapexit_busy",   32'(busy_cycles),  32'(2 * (H + G)));
    check("gapexit_pend",   32'(max_pend),     32'd0);
    check("gapexit_ovf",    32'(ovf_cycles),   32'd0);

    // Asynchronous reset in the third HOLD cycle with two requests queued.
    drive(1'b1); drive(1'b1); drive(1'b1);
    bus.pulse_in = 1'b0;
    check("midhold_pend",  32'(bus.pending),   32'd2);
    check("midhold_press", 32'(bus.press_out), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("async_press", 32'(bus.press_out), 32'd1);
    check("async_busy",  32'(bus.busy),      32'd0);
    check("async_pend",  32'(bus.pending),   32'd0);
    check("async_ovf",   32'(bus.overflow),  32'd0);
    tick();
    tick();
    rst = 1'b0;
    clear_counts();
    repeat (20) drive(1'b0);
    check("postrst_starts", 32'(press_starts), 32'd0);
    check("postrst_busy",   32'(busy_cycles),  32'd0);
    check("postrst_low",    32'(low_cycles),   32'd0);

    // Randomized traffic at varying densities, with occasional resets.
    for (int blk = 0; blk < 16; blk++) begin
      int density;
      case (blk % 4)
        0:       density = 5;
        1:       density = 20;
        2:       density = 60;
        default: density = 95;
      endcase
      for (int c = 0; c < 200; c++) begin
        drive($urandom_range(0, 99) < density);
      end
      if (blk % 5 == 4) begin
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    bus.pulse_in = 1'b0;
    wait_idle("random", 400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_to_press.md
# pulse_to_press

Converts single-cycle press pulses, as produced by the button shaper, back into clean button-style active-low press waveforms of fixed duration. Each accepted pulse yields exactly one press: `HOLD_CYCLES` low, followed by `GAP_CYCLES` high. Pulses arriving while a press is in progress are queued in a saturating pending counter. The block sits between control logic and any consumer expecting a physical-button-like input, such as a downstream shaper, an LED indicator or an off-chip line. It also serves as a synthesizable stimulus source for shaper verification.

## Interface
- `HOLD_CYCLES`, default 8: clock cycles `press_out` is held low per press; must be ≥1.
- `GAP_CYCLES`, default 4: clock cycles `press_out` is held high after each press before the next press may begin; must be ≥1.
- `MAX_PENDING`, default 7: saturation value of the pending queue; must be ≥1.
- `PW`, default 3: width of `pending`; must satisfy 2^PW − 1 ≥ `MAX_PENDING`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `pulse_in` input 1: press request; each rising edge at which it is sampled high counts as one request.
- `press_out` output 1: button-style press, active-low (idle 1, pressed 0); registered.
- `busy` output 1: high whenever state ≠ IDLE; registered.
- `pending` output PW: number of queued requests not yet started; registered.
- `overflow` output 1: one-cycle pulse when a request is dropped because the queue is full; registered.

## Operation
- **States:** IDLE, HOLD, GAP. An internal down-counter is sized for max(`HOLD_CYCLES`, `GAP_CYCLES`).
- **Reset (async, immediate):**
  - state = IDLE, counter = 0.
  - `press_out` = 1, `busy` = 0, `pending` = 0, `overflow` = 0.
- **IDLE:**
  - On an edge with `pulse_in` = 1: go to HOLD and load the counter with `HOLD_CYCLES`−1.
  - `press_out` becomes 0 and `busy` becomes 1 at that same edge.
  - `pending` is unchanged (stays 0).
- **HOLD:**
  - `press_out` = 0; the counter decrements each edge.
  - At the edge where counter = 0: go to GAP, load `GAP_CYCLES`−1, and `press_out` becomes 1.
- **GAP:**
  - `press_out` = 1; the counter decrements each edge.
  - At the edge where counter = 0 (the exit edge):
    - If `pending` > 0 or `pulse_in` = 1: go to HOLD directly, with no IDLE cycle, and load `HOLD_CYCLES`−1.
    - Otherwise go to IDLE.
- **Queueing (HOLD, or GAP on a non-exit edge):**
  - `pulse_in` = 1 with `pending` < `MAX_PENDING`: `pending` increments.
  - `pulse_in` = 1 with `pending` = `MAX_PENDING`: the request is dropped and `overflow` = 1 for the following cycle.
- **GAP exit edge accounting:**
  - Starting a new press: next `pending` = `pending` + `pulse_in` − 1.
  - This sum never goes negative and never overflows, so `overflow` stays 0 on that edge, even when the queue is full.
- **Request counting:**
  - `pulse_in` held high for k edges counts as k requests.
  - No edge detection is performed; upstream is responsible for single-cycle pulses.

## Timing
- **Latency:** `pulse_in` sampled high at edge n in IDLE → `press_out` low from edge n until edge n+`HOLD_CYCLES`.
- **Press shape:**
  - Low for exactly `HOLD_CYCLES` periods, then high for at least `GAP_CYCLES` periods.
  - Back-to-back press period = `HOLD_CYCLES`+`GAP_CYCLES`.
- **`busy`:** falls at the GAP exit edge when no further request is present; an isolated press keeps `busy` high for `HOLD_CYCLES`+`GAP_CYCLES` cycles.
- **`overflow`:** asserted for exactly one cycle per dropped request; consecutive drops give consecutive high cycles.
- **Reset mid-press:**
  - `press_out` returns to 1 asynchronously.
  - The queue is cleared; no press is emitted after reset deasserts unless a new request arrives.
- **Glitch-free output:** `press_out` comes directly from a flop.

## Test plan
All scenarios use the defaults HOLD=8, GAP=4, MAX=7.
- **Reset values:** assert `rst` asynchronously mid-cycle → `press_out`=1, `busy`=0, `pending`=0, `overflow`=0 immediately, without waiting for a clock edge.
- **Single pulse:** one-cycle pulse at edge n → `press_out` low for edges n..n+7 (8 cycles), high thereafter; `busy` high for 12 cycles; `pending` stays 0.
- **Three pulses:** three pulses on edges n, n+2, n+4 → `pending` goes 1 then 2; three presses of 8 low / 4 high with no IDLE between; `pending` reads 1 during press 2 and 0 during press 3.
- **Burst and saturation:** `pulse_in` held high for 10 edges from IDLE →
  - first edge starts a press; `pending` climbs to 7;
  - the last 2 requests are dropped, so `overflow` is high for 2 consecutive cycles;
  - exactly 8 presses total, then `busy`=0.
- **GAP exit coincidence:** pulse coincident with the GAP exit edge while `pending`=0 → HOLD starts at that edge with no IDLE cycle; `pending` remains 0; `overflow` remains 0.
- **Reset mid-HOLD:** assert `rst` at cycle 3 of HOLD with `pending`=2 → `press_out`=1 immediately; after release, `press_out` stays 1 and `busy` stays 0 for 20 cycles with `pulse_in`=0.
